// File: rtl/lcd_cmd_scheduler.sv
// Two-requester LCD command scheduler: per-requester FIFOs, round-robin pick,
// and an issue FSM that follows each command through the controller busy cycle.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | wait for lcd_busy=0 and a queued command; pop one
//   ISSUE     | drive lcd_cmd with lcd_cmd_valid for one cycle
//   WAIT_BUSY | wait for the controller to raise busy (bounded by TIMEOUT)
//   WAIT_DONE | wait for busy to fall, then count the completion
module lcd_cmd_scheduler #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req0_cmd,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req1_cmd,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic       lcd_busy,
  input  logic       lcd_done,
  output logic [3:0] lcd_cmd,
  output logic       lcd_cmd_valid,
  output logic       grant_id,
  output logic [7:0] issued_cnt,
  output logic       err_timeout,
  output logic       err_illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_CNT    = PW'(DEPTH);
  localparam logic [7:0]    TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    mem_q [2][DEPTH];
  logic [PW-1:0] wr_ptr_q [2];
  logic [PW-1:0] wr_ptr_d [2];
  logic [PW-1:0] rd_ptr_q [2];
  logic [PW-1:0] rd_ptr_d [2];
  logic [PW-1:0] cnt_q    [2];
  logic [PW-1:0] cnt_d    [2];
  logic [3:0]    cmd_in   [2];
  logic [1:0]    valid_in;
  logic [1:0]    full;
  logic [1:0]    empty;
  logic [1:0]    accept;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic          illegal_hit;

  logic          grant_q, grant_d;
  logic          rr_q, rr_d;
  logic          gnt;
  logic [3:0]    cmd_q, cmd_d;
  logic [7:0]    timer_q, timer_d;
  logic [7:0]    issued_q, issued_d;
  logic          err_to_q, err_to_d;
  logic          err_ill_q, err_ill_d;

  // Completion is judged by busy falling; done is carried only for visibility.
  logic unused_done;
  assign unused_done = lcd_done;

  // Full is taken from the pre-pop count, so a simultaneous pop never frees a slot.
  always_comb begin
    cmd_in[0]   = req0_cmd;
    cmd_in[1]   = req1_cmd;
    valid_in    = {req1_valid, req0_valid};
    full        = '0;
    empty       = '0;
    accept      = '0;
    push        = '0;
    illegal_hit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      full[i]     = (cnt_q[i] == FULL_CNT);
      empty[i]    = (cnt_q[i] == '0);
      accept[i]   = valid_in[i] & ~full[i];
      push[i]     = accept[i] & (cmd_in[i] < 4'd12);
      illegal_hit = illegal_hit | (accept[i] & (cmd_in[i] >= 4'd12));
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i] + {{AW{1'b0}}, push[i]};
      rd_ptr_d[i] = rd_ptr_q[i] + {{AW{1'b0}}, pop[i]};
      cnt_d[i]    = cnt_q[i] + {{AW{1'b0}}, push[i]} - {{AW{1'b0}}, pop[i]};
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i][AW-1:0]] <= cmd_in[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    pop       = '0;
    gnt       = 1'b0;
    grant_d   = grant_q;
    rr_d      = rr_q;
    cmd_d     = cmd_q;
    timer_d   = timer_q;
    issued_d  = issued_q;
    err_to_d  = err_to_q;
    err_ill_d = err_ill_q | illegal_hit;
    unique case (state_q)
      IDLE: begin
        if (!lcd_busy && (empty != 2'b11)) begin
          gnt      = (empty == 2'b00) ? rr_q : empty[0];
          pop[gnt] = 1'b1;
          grant_d  = gnt;
          rr_d     = ~gnt;
          cmd_d    = mem_q[gnt][rd_ptr_q[gnt][AW-1:0]];
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (lcd_busy) begin
          state_d = WAIT_DONE;
        end else begin
          timer_d = timer_q + 8'd1;
          if (timer_d == TIMEOUT_CNT) begin
            err_to_d = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!lcd_busy) begin
          issued_d = issued_q + 8'd1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      rr_q      <= 1'b0;
      cmd_q     <= '0;
      timer_q   <= '0;
      issued_q  <= '0;
      err_to_q  <= 1'b0;
      err_ill_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      cmd_q     <= cmd_d;
      timer_q   <= timer_d;
      issued_q  <= issued_d;
      err_to_q  <= err_to_d;
      err_ill_q <= err_ill_d;
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  assign req0_ready    = ~full[0];
  assign req1_ready    = ~full[1];
  assign lcd_cmd       = cmd_q;
  assign lcd_cmd_valid = (state_q == ISSUE);
  assign grant_id      = grant_q;
  assign issued_cnt    = issued_q;
  assign err_timeout   = err_to_q;
  assign err_illegal   = err_ill_q;

endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// Directed bench for lcd_cmd_scheduler with a small LCD controller model that
// logs every issue strobe and answers with a fixed busy pulse.
module tb_lcd_cmd_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req0_cmd, req1_cmd;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic       lcd_busy = 1'b1;
  logic       lcd_done = 1'b0;
  logic [3:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic       grant_id;
  logic [7:0] issued_cnt;
  logic       err_timeout, err_illegal;

  int checks = 0;
  int errors = 0;

  // 0: busy follows busy_manual, 1: 3-cycle busy pulse after each strobe, 2: never busy
  int   lcd_mode    = 0;
  logic busy_manual = 1'b1;
  int   busy_cnt    = 0;
  logic [3:0] log_cmd[$];
  logic       log_gid[$];

  lcd_cmd_scheduler #(.DEPTH(4), .TIMEOUT(255)) dut (
    .clk           (clk),
    .reset         (reset),
    .req0_cmd      (req0_cmd),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req1_cmd      (req1_cmd),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .lcd_busy      (lcd_busy),
    .lcd_done      (lcd_done),
    .lcd_cmd       (lcd_cmd),
    .lcd_cmd_valid (lcd_cmd_valid),
    .grant_id      (grant_id),
    .issued_cnt    (issued_cnt),
    .err_timeout   (err_timeout),
    .err_illegal   (err_illegal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always begin
    @(negedge clk);
    if (lcd_cmd_valid === 1'b1) begin
      log_cmd.push_back(lcd_cmd);
      log_gid.push_back(grant_id);
      check_eq("strobe_busy", {7'd0, lcd_busy}, 8'd0);
      if (lcd_mode == 1) busy_cnt = 3;
    end
    @(posedge clk);
    #2;
    case (lcd_mode)
      0: lcd_busy = busy_manual;
      1: begin
        lcd_busy = (busy_cnt > 0);
        lcd_done = (busy_cnt == 1);
        if (busy_cnt > 0) busy_cnt--;
      end
      default: lcd_busy = 1'b0;
    endcase
  end

  function automatic logic [7:0] strobe_cmd(input int idx);
    if (idx < log_cmd.size()) return {4'd0, log_cmd[idx]};
    return 8'hFF;
  endfunction

  function automatic logic [7:0] strobe_gid(input int idx);
    if (idx < log_gid.size()) return {7'd0, log_gid[idx]};
    return 8'hFF;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  task automatic push0(input logic [3:0] c);
    req0_cmd = c; req0_valid = 1'b1;
    step(1);
    req0_valid = 1'b0;
  endtask

  task automatic push1(input logic [3:0] c);
    req1_cmd = c; req1_valid = 1'b1;
    step(1);
    req1_valid = 1'b0;
  endtask

  task automatic push_both(input logic [3:0] c0, input logic [3:0] c1);
    req0_cmd = c0; req0_valid = 1'b1;
    req1_cmd = c1; req1_valid = 1'b1;
    step(1);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_order [8];
    logic       exp_gid   [8];
    logic       seen;
    int         base;
    exp_order = '{4'd1, 4'd5, 4'd2, 4'd6, 4'd3, 4'd7, 4'd4, 4'd8};
    exp_gid   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    reset = 1'b0;
    req0_cmd = '0; req1_cmd = '0; req0_valid = 1'b0; req1_valid = 1'b0;
    lcd_mode = 0; busy_manual = 1'b1;
    step(3);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_lcd_cmd",    {4'd0, lcd_cmd}, 8'd0);
    check_eq("rst_valid",      {7'd0, lcd_cmd_valid}, 8'd0);
    check_eq("rst_grant",      {7'd0, grant_id}, 8'd0);
    check_eq("rst_issued",     issued_cnt, 8'd0);
    check_eq("rst_err_to",     {7'd0, err_timeout}, 8'd0);
    check_eq("rst_err_ill",    {7'd0, err_illegal}, 8'd0);
    check_eq("rst_ready0",     {7'd0, req0_ready}, 8'd1);
    check_eq("rst_ready1",     {7'd0, req1_ready}, 8'd1);

    // 1: controller busy after power-up holds off the first issue
    step(20);
    base = log_cmd.size();
    push0(4'd0);
    step(5);
    @(negedge clk);
    check_eq("t1_no_strobe_busy", 8'(log_cmd.size() - base), 8'd0);
    step(1);
    lcd_mode = 1;
    step(15);
    @(negedge clk);
    check_eq("t1_strobes", 8'(log_cmd.size() - base), 8'd1);
    check_eq("t1_cmd",     strobe_cmd(base), 8'd0);
    check_eq("t1_gid",     strobe_gid(base), 8'd0);
    check_eq("t1_issued",  issued_cnt, 8'd1);

    // 2: round-robin across two full FIFOs
    step(1);
    lcd_mode = 0; busy_manual = 1'b1;
    do_reset();
    base = log_cmd.size();
    push_both(4'd1, 4'd5);
    push_both(4'd2, 4'd6);
    push_both(4'd3, 4'd7);
    push_both(4'd4, 4'd8);
    @(negedge clk);
    check_eq("t2_ready0_full", {7'd0, req0_ready}, 8'd0);
    check_eq("t2_ready1_full", {7'd0, req1_ready}, 8'd0);
    step(1);
    lcd_mode = 1;
    step(70);
    @(negedge clk);
    check_eq("t2_strobes", 8'(log_cmd.size() - base), 8'd8);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("t2_cmd%0d", i), strobe_cmd(base + i), {4'd0, exp_order[i]});
      check_eq($sformatf("t2_gid%0d", i), strobe_gid(base + i), {7'd0, exp_gid[i]});
    end
    check_eq("t2_issued", issued_cnt, 8'd8);

    // 3: push into a full FIFO in the cycle it pops is refused
    step(1);
    lcd_mode = 0; busy_manual = 1'b1;
    do_reset();
    base = log_cmd.size();
    push1(4'd2); push1(4'd3); push1(4'd4); push1(4'd5);
    @(negedge clk);
    check_eq("t3_ready1_full", {7'd0, req1_ready}, 8'd0);
    step(1);
    lcd_mode = 1;
    req1_cmd = 4'd9; req1_valid = 1'b1;
    @(negedge clk);
    check_eq("t3_ready_at_pop", {7'd0, req1_ready}, 8'd0);
    step(1);
    req1_valid = 1'b0;
    step(60);
    @(negedge clk);
    check_eq("t3_strobes", 8'(log_cmd.size() - base), 8'd4);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("t3_cmd%0d", i), strobe_cmd(base + i), 8'(i + 2));
    check_eq("t3_issued", issued_cnt, 8'd4);

    // 4: controller never answers -> timeout, then the next command still goes out
    step(1);
    lcd_mode = 2;
    do_reset();
    base = log_cmd.size();
    push0(4'd3);
    push0(4'd4);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (lcd_cmd_valid) seen = 1'b1;
    end
    check_eq("t4_strobe_seen", {7'd0, seen}, 8'd1);
    repeat (255) @(negedge clk);
    check_eq("t4_err_before", {7'd0, err_timeout}, 8'd0);
    @(negedge clk);
    check_eq("t4_err_after", {7'd0, err_timeout}, 8'd1);
    check_eq("t4_issued_hold", issued_cnt, 8'd0);
    lcd_mode = 1;
    step(15);
    @(negedge clk);
    check_eq("t4_strobes", 8'(log_cmd.size() - base), 8'd2);
    check_eq("t4_next_cmd", strobe_cmd(base + 1), 8'd4);
    check_eq("t4_issued", issued_cnt, 8'd1);
    check_eq("t4_err_sticky", {7'd0, err_timeout}, 8'd1);

    // 5: illegal opcode is swallowed and flagged
    step(1);
    lcd_mode = 1;
    do_reset();
    base = log_cmd.size();
    @(negedge clk);
    check_eq("t5_err_clear", {7'd0, err_illegal}, 8'd0);
    step(1);
    push0(4'd13);
    @(negedge clk);
    check_eq("t5_err_ill", {7'd0, err_illegal}, 8'd1);
    step(10);
    @(negedge clk);
    check_eq("t5_no_strobe", 8'(log_cmd.size() - base), 8'd0);
    step(1);
    push0(4'd7);
    step(15);
    @(negedge clk);
    check_eq("t5_strobes", 8'(log_cmd.size() - base), 8'd1);
    check_eq("t5_cmd", strobe_cmd(base), 8'd7);
    check_eq("t5_issued", issued_cnt, 8'd1);
    check_eq("t5_err_sticky", {7'd0, err_illegal}, 8'd1);

    // 6: reset while a command is in WAIT_DONE with three more queued
    step(1);
    lcd_mode = 0; busy_manual = 1'b1;
    do_reset();
    push0(4'd1); push0(4'd2); push0(4'd3); push0(4'd4);
    busy_manual = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (lcd_cmd_valid) seen = 1'b1;
    end
    busy_manual = 1'b1;
    check_eq("t6_strobe_seen", {7'd0, seen}, 8'd1);
    repeat (3) @(negedge clk);
    check_eq("t6_cmd_before", {4'd0, lcd_cmd}, 8'd1);
    #1 reset = 1'b0;
    #1;
    check_eq("t6_rst_cmd",    {4'd0, lcd_cmd}, 8'd0);
    check_eq("t6_rst_valid",  {7'd0, lcd_cmd_valid}, 8'd0);
    check_eq("t6_rst_grant",  {7'd0, grant_id}, 8'd0);
    check_eq("t6_rst_issued", issued_cnt, 8'd0);
    check_eq("t6_rst_ready0", {7'd0, req0_ready}, 8'd1);
    step(2);
    reset = 1'b1;
    lcd_mode = 1;
    base = log_cmd.size();
    step(12);
    @(negedge clk);
    check_eq("t6_no_strobe", 8'(log_cmd.size() - base), 8'd0);
    check_eq("t6_issued",    issued_cnt, 8'd0);
    step(1);
    push0(4'd9);
    step(15);
    @(negedge clk);
    check_eq("t6_new_strobes", 8'(log_cmd.size() - base), 8'd1);
    check_eq("t6_new_cmd",     strobe_cmd(base), 8'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_scheduler.md
Name: lcd_cmd_scheduler

Overview:
Arbitrates LCD image-processing commands from two independent requesters and feeds them, one at a time, to the LCD controller's cmd/cmd_valid/busy/done interface. Each requester gets a small command FIFO. A round-robin arbiter picks the next command, and an issue FSM tracks each command through the controller's busy/done cycle. The block sits between the host-side command sources and the LCD controller, and also reports completion counts and error flags.

Parameters:
DEPTH, 4, entries per requester FIFO (power of 2, >=2)
TIMEOUT, 255, max cycles to wait for lcd_busy to rise after an issue (8-bit counter)

Ports:
clk  in  1  single clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
req0_cmd  in  4  requester 0 command opcode
req0_valid  in  1  requester 0 command present
req0_ready  out  1  requester 0 FIFO can accept (not full)
req1_cmd  in  4  requester 1 command opcode
req1_valid  in  1  requester 1 command present
req1_ready  out  1  requester 1 FIFO can accept (not full)
lcd_busy  in  1  LCD controller busy level
lcd_done  in  1  LCD controller done level
lcd_cmd  out  4  command to LCD controller
lcd_cmd_valid  out  1  one-cycle issue strobe
grant_id  out  1  requester whose command is in flight (valid while not IDLE)
issued_cnt  out  8  completed-command count, wraps 255->0
err_timeout  out  1  sticky: issued command never raised lcd_busy
err_illegal  out  1  sticky: opcode 12..15 presented and accepted

Behaviour:
- Reset (reset=0, asynchronous): both FIFOs empty; FSM=IDLE; lcd_cmd=0, lcd_cmd_valid=0, grant_id=0, issued_cnt=0, err_timeout=0, err_illegal=0; rr pointer=0 (requester 0 preferred). Reset mid-operation discards queued and in-flight commands.
- Enqueue: push when reqN_valid && reqN_ready. reqN_ready = !full, with full computed from the pre-pop count. A push into a full FIFO is refused even if a pop happens in the same cycle.
- Illegal opcode (cmd >= 12): the handshake completes but the entry is not stored, and err_illegal is set.
- Error flags clear only on reset.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE: the LCD controller powers up busy while loading its image, so IDLE waits until lcd_busy=0 and at least one FIFO is non-empty. Then it pops one entry and goes to ISSUE.
  - Arbiter: if both FIFOs are non-empty, grant the requester named by rr and set rr to the other one. If only one is non-empty, grant it and set rr to the other one.
  - grant_id is registered together with the pop.
- ISSUE (1 cycle): lcd_cmd = popped opcode and lcd_cmd_valid=1 for exactly this cycle. lcd_cmd holds its value until the next issue. Timer is cleared. Next state is WAIT_BUSY.
- WAIT_BUSY: if lcd_busy=1, go to WAIT_DONE. Otherwise the timer increments; when it reaches TIMEOUT, set err_timeout, drop the command (no count) and go to IDLE.
- WAIT_DONE: when lcd_busy=0, increment issued_cnt and go to IDLE. lcd_done is informational only; busy falling is the completion condition.
- Latency: a command pushed into an empty FIFO while the FSM is IDLE and lcd_busy=0 is popped the next cycle and strobed one cycle after that (valid to strobe = 2 cycles). The minimum spacing between consecutive strobes is 4 cycles.
- No command is issued while lcd_busy=1, and there is never more than one command in flight.
- FIFO pointers are log2(DEPTH)+1 bits, wrap naturally, and use a per-FIFO count for full/empty.

Test Plan:
1. Hold lcd_busy=1 for 20 cycles after reset, push req0 cmd=0, then drop busy -> no strobe before busy=0; exactly one strobe with lcd_cmd=0, grant_id=0; after a busy pulse, issued_cnt=1.
2. Fill both FIFOs (req0: 1,2,3,4; req1: 5,6,7,8) with the LCD model idle -> issue order 1,5,2,6,3,7,4,8; issued_cnt=8; req0_ready=0 after the 4th push.
3. Push a 5th entry into the full req1 FIFO during the cycle it pops -> push refused (req1_ready=0); the 5th command is never issued.
4. Issue with an LCD model that never raises busy -> after 255 WAIT_BUSY cycles err_timeout=1, issued_cnt unchanged, next queued command still issued.
5. Push req0 cmd=13 -> err_illegal=1, nothing issued; a later cmd=7 issues normally.
6. Assert reset=0 during WAIT_DONE with 3 entries queued -> all outputs return to reset values immediately; after release no strobe occurs until new pushes.
